// File: rtl/uart_rx_if.sv
// Byte-stream interface between uart_rx and its consumer (the UART register block).
// master = receiver side, slave = consumer side.
interface uart_rx_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   modport master (
      output data,
      output valid,
      output frame_err,
      output overrun,
      output busy,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      input  frame_err,
      input  overrun,
      input  busy,
      output ready
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and a valid/ready byte output.
// Optional build macro UART_RX_FIFO_EN replaces the single holding register
// with a 4-entry FIFO; interface and timing are unchanged.
module uart_rx #(
   parameter int unsigned DIV = 54
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   uart_rx_if.master  bus
);

   localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitIdle} state_e;

   state_e          state_q, state_d;
   logic            rx_meta_q, rx_s_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [7:0]      idx_q, idx_d;     // ticks completed since START entry
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            tick;
   logic            stop_ok, stop_bad;
   logic            ferr_q, ferr_d;
   logic            ovr_q, ovr_d;
   logic            pop;

   // Two-flop synchronizer; idles high so reset never looks like a start bit
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
      end
   end

   // FSM and sampling-counter state registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   assign tick = (cnt_q == CntMax);

   // Next-state logic; tick index n fires with idx_q == n-1
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      stop_ok  = 1'b0;
      stop_bad = 1'b0;

      if (state_q != StIdle && state_q != StWaitIdle) begin
         cnt_d = tick ? '0 : cnt_q + CntW'(1);
         if (tick) idx_d = idx_q + 8'd1;
      end

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            idx_d = '0;
            bit_d = '0;
            if (!rx_s_q) state_d = StStart;
         end
         StStart: begin
            // Mid start bit: still low means a real frame, else a glitch
            if (tick && idx_q == 8'd7) state_d = rx_s_q ? StIdle : StData;
         end
         StData: begin
            // Bit centres fall on ticks 24, 40, ..., 136 (idx low nibble == 7)
            if (tick && idx_q[3:0] == 4'd7) begin
               shift_d = {rx_s_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = StStop;
            end
         end
         StStop: begin
            if (tick && idx_q == 8'd151) begin
               if (rx_s_q) begin
                  stop_ok = 1'b1;
                  state_d = StIdle;
               end else begin
                  stop_bad = 1'b1;
                  state_d  = StWaitIdle;
               end
            end
         end
         StWaitIdle: begin
            // Line held low (break): wait for it to return high
            cnt_d = '0;
            idx_d = '0;
            if (rx_s_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign ferr_d = stop_bad;

`ifdef UART_RX_FIFO_EN
   logic [7:0] mem_q [4];
   logic [7:0] mem_d [4];
   logic [1:0] wr_q, wr_d, rd_q, rd_d;
   logic [2:0] fcnt_q, fcnt_d;
   logic       push;

   assign pop  = (fcnt_q != 3'd0) && bus.ready;
   assign push = stop_ok && ((fcnt_q != 3'd4) || pop);

   // FIFO next-state: pointers wrap naturally at 2 bits
   always_comb begin
      mem_d  = mem_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      fcnt_d = fcnt_q;
      ovr_d  = stop_ok && !push;
      if (push) begin
         mem_d[wr_q] = shift_q;
         wr_d        = wr_q + 2'd1;
      end
      if (pop) rd_d = rd_q + 2'd1;
      case ({push, pop})
         2'b10:   fcnt_d = fcnt_q + 3'd1;
         2'b01:   fcnt_d = fcnt_q - 3'd1;
         default: fcnt_d = fcnt_q;
      endcase
   end

   // FIFO storage and flag pulse registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 4; i++) mem_q[i] <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         fcnt_q <= '0;
         ferr_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         mem_q  <= mem_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         fcnt_q <= fcnt_d;
         ferr_q <= ferr_d;
         ovr_q  <= ovr_d;
      end
   end

   assign bus.valid = (fcnt_q != 3'd0);
   assign bus.data  = mem_q[rd_q];
`else
   logic       hv_q, hv_d;
   logic [7:0] hd_q, hd_d;

   assign pop = hv_q && bus.ready;

   // Holding register: a same-cycle pop frees the slot for the new byte
   always_comb begin
      hv_d  = hv_q;
      hd_d  = hd_q;
      ovr_d = 1'b0;
      if (stop_ok) begin
         if (!hv_q || pop) begin
            hv_d = 1'b1;
            hd_d = shift_q;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (pop) begin
         hv_d = 1'b0;
      end
   end

   // Holding register and flag pulse registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hv_q   <= 1'b0;
         hd_q   <= '0;
         ferr_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         hv_q   <= hv_d;
         hd_q   <= hd_d;
         ferr_q <= ferr_d;
         ovr_q  <= ovr_d;
      end
   end

   assign bus.valid = hv_q;
   assign bus.data  = hd_q;
`endif

   assign bus.frame_err = ferr_q;
   assign bus.overrun   = ovr_q;
   assign bus.busy      = (state_q != StIdle);

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the SoC `rx` pin, the receiving counterpart of the `tx` line the SoC drives. It recovers 8N1 asynchronous frames (1 start, 8 data LSB first, 1 stop) using 16x oversampling and presents each byte on a valid/ready interface. The core's memory-mapped UART register block pops bytes from it. It flags framing errors and overruns as single-cycle pulses.

## Interface
- `DIV`, 54: clocks per oversample tick, equal to clk/(16*baud); 54 gives 115200 baud at 100 MHz; legal range ≥ 2.
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `rx`  in  1  asynchronous serial input; idle high
- `data`  out  8  received byte; meaningful only while `valid`=1
- `valid`  out  1  byte available
- `ready`  in  1  consumer accepts; a transfer occurs on a cycle with `valid`&&`ready`
- `frame_err`  out  1  one-cycle pulse when a stop bit samples 0
- `overrun`  out  1  one-cycle pulse when a completed byte is dropped
- `busy`  out  1  receiver not in IDLE

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`. The synchronizer flops reset to 1.
- Tick counter:
  - Counts 0..DIV-1 and emits a tick when it reaches DIV-1.
  - Cleared on entry to START.
  - Held at 0 in IDLE and WAIT_IDLE.
  - Width is $clog2(DIV).
- The tick index counts ticks since START entry.
- FSM states are IDLE, START, DATA, STOP and WAIT_IDLE.
  - IDLE: on `rx_s`=0, go to START.
  - START: at tick 8 (mid start bit), if `rx_s`=0 go to DATA. Otherwise go to IDLE (glitch reject, nothing reported).
  - DATA: at ticks 24, 40, …, 136 (every 16 ticks), shift `rx_s` into the MSB of a shift register, shifting right. After the 8th bit, go to STOP.
  - STOP: at tick 152, sample `rx_s`.
    - If 1, deliver the byte and go to IDLE in the same cycle, so the next start edge is detected without a gap.
    - If 0, pulse `frame_err`, discard the byte, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s`=1, then go to IDLE. This handles the break condition.
- Delivery:
  - The byte is stored if the holding register is empty, or if it is being popped in the same cycle.
  - Otherwise `overrun` pulses, the new byte is dropped, and the stored byte is unchanged.
- `valid` stays asserted until the byte is accepted. `data` is stable while `valid`=1.
- `busy` = (state ≠ IDLE).
- A synchronous `rst` at any point, including mid-frame:
  - FSM goes to IDLE and counters clear.
  - Stored bytes are discarded.
  - All outputs take their reset values.

## Timing
- Reset values: `data`=8'h00, `valid`=0, `frame_err`=0, `overrun`=0, `busy`=0.
- Let E be the first cycle in which `rx_s`=0 in IDLE. This is 2 clocks after the falling `rx` edge is first captured.
- Start-bit check occurs at E+8·DIV.
- Stop-bit sample occurs at E+152·DIV.
- At the stop-bit sample, `valid` (or `frame_err`/`overrun`) asserts the next cycle, E+152·DIV+1.
- `frame_err` and `overrun` are high for exactly 1 cycle per event.
- If a pop and a new delivery occur in the same cycle, the new byte is loaded, `valid` stays 1, and no overrun is reported.
- Frame period at `rx` is 160·DIV clocks. The receiver is back in IDLE 8·DIV clocks before the nominal frame end.

## Configuration
- `UART_RX_FIFO_EN`:
  - Defined: the holding register is replaced by a 4-entry FIFO.
    - `valid` = not empty; `data` = head entry.
    - Pop occurs on `valid`&&`ready`.
    - `overrun` pulses only when the FIFO holds 4 entries and no pop occurs in the delivery cycle.
    - Pointers wrap modulo 4.
    - Reset empties the FIFO.
  - Undefined: single-entry holding register as described above.
- Interface and timing are identical in both builds.

## Test plan
All scenarios use DIV=4, giving a bit period of 64 cycles.
- Send 0x55 with `ready`=1 → exactly one `valid` cycle with `data`=0x55 at E+609; `frame_err`=0; `busy` returns to 0.
- Drive `rx` low for 16 cycles, then high → no `valid` and no flags; `busy` returns to 0 by E+33.
- Send 0xA5 with a stop bit of 0, then hold `rx` low for 300 cycles → one `frame_err` pulse, no `valid`; `busy`=1 until 2 cycles after `rx` rises.
- Hold `ready`=0 and send 0x12 then 0x34 → `valid` holds `data`=0x12, one `overrun` pulse at the second stop sample; raising `ready` yields 0x12 only. In the FIFO build, send 5 bytes: the 5th overruns and the first 4 drain in order.
- Send 0x00 and 0xFF back-to-back with no idle gap, `ready`=1 → 0x00 then 0xFF delivered, no flags.
- Assert `rst` for 1 cycle during data bit 3 of 0x77 → all outputs at reset values the next cycle; a following frame 0x3C is received correctly.
